hermes_packet_tx: RTL and testbench
===================================

HERMES_PACKET_TX -- requirements
Module: hermes_packet_tx

Interface
REQ-001 SHALL have parameter FLIT_SIZE, default 32, flit width in bits (minimum 20).
REQ-002 SHALL have port clk_i  input  1  clock, rising-edge active.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start_i  input  1  request to inject one packet.
REQ-005 SHALL have port header_i  input  FLIT_SIZE  header flit (target address), sampled when start accepted.
REQ-006 SHALL have port size_i  input  FLIT_SIZE  payload flit count, sampled when start accepted.
REQ-007 SHALL have port start_ready_o  output  1  high when a start can be accepted.
REQ-008 SHALL have port pl_valid_i  input  1  payload flit valid from local source.
REQ-009 SHALL have port pl_data_i  input  FLIT_SIZE  payload flit.
REQ-010 SHALL have port pl_ready_o  output  1  payload flit accepted on this edge when pl_valid_i also high.
REQ-011 SHALL have port tx_o  output  1  flit valid on link.
REQ-012 SHALL have port data_o  output  FLIT_SIZE  link flit.
REQ-013 SHALL have port credit_i  input  1  receiving buffer not full.
REQ-014 SHALL have port done_o  output  1  one-cycle pulse after the last payload flit is transferred.
REQ-015 SHALL have port err_o  output  1  one-cycle pulse when a start with size_i == 0 is rejected.

Function
REQ-016 Link transfer SHALL occur on a rising edge where tx_o && credit_i; tx_o and data_o SHALL hold stable until that transfer.
REQ-017 tx_o and data_o SHALL be driven from registers (one-entry output stage); no combinational path from credit_i or pl_* to tx_o/data_o.
REQ-018 FSM states SHALL be IDLE, HEADER, SIZE, PAYLOAD, DONE, one-hot encoded.
REQ-019 IDLE: start_ready_o = 1; start_i && size_i != 0 -> load output stage with header_i, tx_o = 1 next cycle, latch size_i into send and accept counters, go HEADER.
REQ-020 IDLE: start_i && size_i == 0 -> stay IDLE, err_o pulses next cycle, no link activity.
REQ-021 HEADER: on transfer, load output stage with latched size, go SIZE.
REQ-022 SIZE: on transfer, tx_o drops unless a payload flit is loaded the same edge, go PAYLOAD.
REQ-023 pl_ready_o SHALL be 1 only in SIZE or PAYLOAD, accept counter != 0, and (output stage empty or transferring this edge); it SHALL be 0 in all other states.
REQ-024 Payload accept SHALL load the output stage and decrement the accept counter; back-to-back flits SHALL sustain one flit per cycle while credit_i stays high.
REQ-025 Each payload transfer SHALL decrement the send counter; transfer with send counter == 1 SHALL move PAYLOAD -> DONE, tx_o = 0.
REQ-026 DONE: done_o = 1 for exactly one cycle, then IDLE; start_i in DONE is ignored.
REQ-027 Counters SHALL be FLIT_SIZE wide, unsigned, never wrap (decrement only when nonzero).
REQ-028 credit_i low SHALL stall with state, counters, tx_o, data_o unchanged; pl_valid_i low SHALL only create bubbles (tx_o = 0), never reorder flits.
REQ-029 Flit order on link SHALL be header, size, then exactly size_i payload flits in source order.

Reset
REQ-030 Reset SHALL force state IDLE, counters 0, output stage empty, data_o 0.
REQ-031 Reset values: tx_o 0, data_o 0, pl_ready_o 0, done_o 0, err_o 0, start_ready_o 1 (combinational from IDLE).
REQ-032 Reset mid-packet SHALL abort immediately with no further flits; packet is discarded.

Structure
REQ-033 FSM state typedef and flit-width default constant SHALL reside in shared package hermes_pkg.
REQ-034 Single module, no sub-module; output stage and counters inline.

Verification
REQ-035 header 0x0000_0102, size 3, payload A,B,C always valid, credit_i = 1 -> link flits 0x102, 3, A, B, C on 5 consecutive edges, done_o 1 cycle after C.
REQ-036 Same packet, credit_i low 4 cycles while size flit on link -> data_o holds 3, tx_o held 1, no extra flits, order intact.
REQ-037 size 2, pl_valid_i gapped (1,0,0,1) -> tx_o bubbles, exactly 2 payload flits, then DONE.
REQ-038 start_i with size 0 -> err_o single pulse, tx_o stays 0, start_ready_o stays 1.
REQ-039 rst_ni asserted after second payload of size 8 -> tx_o 0 same cycle, IDLE, next packet size 1 sent correctly.
REQ-040 Two packets back-to-back (size 1, size 2), start_i held high -> second header appears only after done_o, flit count 3 + 4.

Source files
------------

// File: rtl/hermes_pkg.sv
// +----------------------------------------------------------------------+
// | hermes_pkg : shared FSM state type and flit-width default            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package hermes_pkg;

   localparam int unsigned c_flit_size = 32;

   typedef enum logic [4:0] {
      S_IDLE    = 5'b00001,
      S_HEADER  = 5'b00010,
      S_SIZE    = 5'b00100,
      S_PAYLOAD = 5'b01000,
      S_DONE    = 5'b10000
   } state_e;

endpackage

`default_nettype wire

// File: rtl/hermes_packet_tx.sv
// +----------------------------------------------------------------------+
// | hermes_packet_tx : injects header, size and payload flits on a       |
// | credit-based link through a registered one-entry output stage        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module hermes_packet_tx
   import hermes_pkg::*;
#(
   parameter int unsigned FLIT_SIZE = c_flit_size
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic [FLIT_SIZE-1:0] header_i,
   input  logic [FLIT_SIZE-1:0] size_i,
   output logic                 start_ready_o,
   input  logic                 pl_valid_i,
   input  logic [FLIT_SIZE-1:0] pl_data_i,
   output logic                 pl_ready_o,
   output logic                 tx_o,
   output logic [FLIT_SIZE-1:0] data_o,
   input  logic                 credit_i,
   output logic                 done_o,
   output logic                 err_o
);

   localparam logic [FLIT_SIZE-1:0] c_one = FLIT_SIZE'(1);

   state_e               r_state;
   state_e               w_state_nxt;
   logic                 r_tx;
   logic [FLIT_SIZE-1:0] r_data;
   logic [FLIT_SIZE-1:0] r_send_cnt;
   logic [FLIT_SIZE-1:0] r_acc_cnt;
   logic                 r_err;

   logic w_xfer;
   logic w_in_pl;
   logic w_accept;
   logic w_start_ok;
   logic w_start_bad;
   logic w_last;

   assign w_xfer      = r_tx & credit_i;
   assign w_in_pl     = (r_state == S_SIZE) || (r_state == S_PAYLOAD);
   // A new payload flit may enter only if the output stage frees up on this edge
   assign pl_ready_o  = w_in_pl && (r_acc_cnt != '0) && (!r_tx || w_xfer);
   assign w_accept    = pl_valid_i & pl_ready_o;
   assign w_start_ok  = (r_state == S_IDLE) && start_i && (size_i != '0);
   assign w_start_bad = (r_state == S_IDLE) && start_i && (size_i == '0);
   assign w_last      = (r_state == S_PAYLOAD) && w_xfer && (r_send_cnt == c_one);

   assign tx_o   = r_tx;
   assign data_o = r_data;
   assign err_o  = r_err;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      start_ready_o = 1'b0;
      done_o        = 1'b0;
      case (r_state)
         S_IDLE: begin
            start_ready_o = 1'b1;
            if (w_start_ok) w_state_nxt = S_HEADER;
         end
         S_HEADER: begin
            if (w_xfer) w_state_nxt = S_SIZE;
         end
         S_SIZE: begin
            if (w_xfer) w_state_nxt = S_PAYLOAD;
         end
         S_PAYLOAD: begin
            if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            done_o      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_tx       <= 1'b0;
         r_data     <= '0;
         r_send_cnt <= '0;
         r_acc_cnt  <= '0;
         r_err      <= 1'b0;
      end else begin
         r_err <= w_start_bad;
         case (r_state)
            S_IDLE: begin
               if (w_start_ok) begin
                  r_tx       <= 1'b1;
                  r_data     <= header_i;
                  r_send_cnt <= size_i;
                  r_acc_cnt  <= size_i;
               end
            end
            S_HEADER: begin
               // Send counter still holds the untouched packet size here
               if (w_xfer) r_data <= r_send_cnt;
            end
            default: begin
               if (w_accept) begin
                  r_tx   <= 1'b1;
                  r_data <= pl_data_i;
               end else if (w_xfer) begin
                  r_tx <= 1'b0;
               end
            end
         endcase
         if (w_accept && (r_acc_cnt != '0)) begin
            r_acc_cnt <= r_acc_cnt - c_one;
         end
         if ((r_state == S_PAYLOAD) && w_xfer && (r_send_cnt != '0)) begin
            r_send_cnt <= r_send_cnt - c_one;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_hermes_packet_tx.sv
// +----------------------------------------------------------------------+
// | tb_hermes_packet_tx : directed scoreboard bench for hermes_packet_tx |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_hermes_packet_tx;

   localparam int W = 32;

   logic         clk_i = 1'b0;
   logic         rst_ni;
   logic         start_i;
   logic [W-1:0] header_i;
   logic [W-1:0] size_i;
   logic         start_ready_o;
   logic         pl_valid_i;
   logic [W-1:0] pl_data_i;
   logic         pl_ready_o;
   logic         tx_o;
   logic [W-1:0] data_o;
   logic         credit_i;
   logic         done_o;
   logic         err_o;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] src_q[$];
   int           gap_q[$];
   int           xfer_t[$];
   int           done_t[$];
   logic         src_abort = 1'b0;

   logic [W-1:0] s_d;
   int           s_g;
   logic         s_acc;

   always #5 clk_i = ~clk_i;

   hermes_packet_tx #(.FLIT_SIZE(W)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .start_i       (start_i),
      .header_i      (header_i),
      .size_i        (size_i),
      .start_ready_o (start_ready_o),
      .pl_valid_i    (pl_valid_i),
      .pl_data_i     (pl_data_i),
      .pl_ready_o    (pl_ready_o),
      .tx_o          (tx_o),
      .data_o        (data_o),
      .credit_i      (credit_i),
      .done_o        (done_o),
      .err_o         (err_o)
   );

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk_i);
      #1;
   endtask

   // Link monitor: a flit moves on the edge following a negedge with tx_o && credit_i
   always @(negedge clk_i) begin
      cyc <= cyc + 1;
      if (rst_ni && tx_o && credit_i) begin
         xfer_t.push_back(cyc);
         if (exp_q.size() == 0) check("extra_flit", {31'b0, tx_o}, 32'd0);
         else check("flit", data_o, exp_q.pop_front());
      end
      if (done_o) done_t.push_back(cyc);
   end

   // Local payload source: presents queued flits in order, holds each until accepted
   initial begin
      pl_valid_i = 1'b0;
      pl_data_i  = '0;
      forever begin
         if (src_q.size() == 0) begin
            pl_valid_i = 1'b0;
            cycle();
         end else begin
            s_g = gap_q.pop_front();
            s_d = src_q.pop_front();
            if (s_g > 0) begin
               pl_valid_i = 1'b0;
               repeat (s_g) cycle();
            end
            pl_valid_i = 1'b1;
            pl_data_i  = s_d;
            s_acc      = 1'b0;
            while (!s_acc) begin
               @(negedge clk_i);
               s_acc = pl_ready_o || src_abort;
               cycle();
            end
            pl_valid_i = 1'b0;
         end
      end
   end

   task automatic queue_packet(input logic [W-1:0] hdr, input int n, input logic [W-1:0] seed,
                               input int gap2);
      exp_q.push_back(hdr);
      exp_q.push_back(W'(n));
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(seed + W'(i));
         src_q.push_back(seed + W'(i));
         gap_q.push_back((i == 1) ? gap2 : 0);
      end
   endtask

   task automatic start_pkt(input logic [W-1:0] hdr, input int n);
      logic rdy;
      header_i = hdr;
      size_i   = W'(n);
      start_i  = 1'b1;
      rdy      = 1'b0;
      for (int k = 0; k < 50 && !rdy; k++) begin
         @(negedge clk_i);
         rdy = start_ready_o;
         cycle();
      end
      start_i = 1'b0;
      check("start_accept", {31'b0, rdy}, 32'd1);
   endtask

   task automatic wait_done(input int n0);
      logic ok;
      ok = 1'b0;
      for (int k = 0; k < 300 && !ok; k++) begin
         cycle();
         ok = (done_t.size() > n0);
      end
      check("done_seen", {31'b0, ok}, 32'd1);
      cycle();
      cycle();
   endtask

   initial begin : main
      int  base;
      int  nd;
      logic rdy;
      rst_ni   = 1'b0;
      start_i  = 1'b0;
      header_i = '0;
      size_i   = '0;
      credit_i = 1'b1;

      @(negedge clk_i);
      check("rst_tx", {31'b0, tx_o}, 32'd0);
      check("rst_data", data_o, 32'd0);
      check("rst_pl_ready", {31'b0, pl_ready_o}, 32'd0);
      check("rst_done", {31'b0, done_o}, 32'd0);
      check("rst_err", {31'b0, err_o}, 32'd0);
      check("rst_start_ready", {31'b0, start_ready_o}, 32'd1);
      cycle();
      cycle();
      rst_ni = 1'b1;
      cycle();

      // Basic packet, streaming without stalls
      base = xfer_t.size();
      nd   = done_t.size();
      queue_packet(32'h0000_0102, 3, 32'hA, 0);
      start_pkt(32'h0000_0102, 3);
      wait_done(nd);
      check("basic_count", W'(xfer_t.size() - base), 32'd5);
      check("basic_consec", W'(xfer_t[base+4] - xfer_t[base]), 32'd4);
      check("basic_done_lat", W'(done_t[nd] - xfer_t[base+4]), 32'd1);
      check("basic_done_once", W'(done_t.size() - nd), 32'd1);
      check("basic_sb_empty", W'(exp_q.size()), 32'd0);

      // Credit stall while the size flit is on the link
      base = xfer_t.size();
      nd   = done_t.size();
      queue_packet(32'h0000_0102, 3, 32'h10, 0);
      start_pkt(32'h0000_0102, 3);
      cycle();
      credit_i = 1'b0;
      repeat (4) begin
         @(negedge clk_i);
         check("stall_tx", {31'b0, tx_o}, 32'd1);
         check("stall_data", data_o, 32'd3);
         cycle();
      end
      credit_i = 1'b1;
      wait_done(nd);
      check("stall_count", W'(xfer_t.size() - base), 32'd5);
      check("stall_span", W'(xfer_t[base+4] - xfer_t[base]), 32'd8);
      check("stall_sb_empty", W'(exp_q.size()), 32'd0);

      // Gapped payload source creates link bubbles
      base = xfer_t.size();
      nd   = done_t.size();
      queue_packet(32'h0000_0203, 2, 32'h20, 2);
      start_pkt(32'h0000_0203, 2);
      wait_done(nd);
      check("gap_count", W'(xfer_t.size() - base), 32'd4);
      check("gap_span", W'(xfer_t[base+3] - xfer_t[base]), 32'd5);
      check("gap_sb_empty", W'(exp_q.size()), 32'd0);

      // Zero-size start is rejected
      nd       = done_t.size();
      header_i = 32'h55;
      size_i   = '0;
      start_i  = 1'b1;
      @(negedge clk_i);
      check("zero_ready_pre", {31'b0, start_ready_o}, 32'd1);
      cycle();
      start_i = 1'b0;
      @(negedge clk_i);
      check("zero_err", {31'b0, err_o}, 32'd1);
      check("zero_tx", {31'b0, tx_o}, 32'd0);
      check("zero_ready", {31'b0, start_ready_o}, 32'd1);
      cycle();
      @(negedge clk_i);
      check("zero_err_pulse", {31'b0, err_o}, 32'd0);
      check("zero_tx_after", {31'b0, tx_o}, 32'd0);
      check("zero_no_done", W'(done_t.size() - nd), 32'd0);
      cycle();

      // Reset in the middle of a size-8 packet
      base = xfer_t.size();
      nd   = done_t.size();
      queue_packet(32'h0000_0304, 8, 32'h30, 0);
      start_pkt(32'h0000_0304, 8);
      rdy = 1'b0;
      for (int k = 0; k < 100 && !rdy; k++) begin
         cycle();
         rdy = ((xfer_t.size() - base) >= 4);
      end
      check("rst_mid_reached", {31'b0, rdy}, 32'd1);
      rst_ni    = 1'b0;
      src_abort = 1'b1;
      exp_q.delete();
      src_q.delete();
      gap_q.delete();
      #1;
      check("rst_mid_tx", {31'b0, tx_o}, 32'd0);
      check("rst_mid_data", data_o, 32'd0);
      check("rst_mid_pl_ready", {31'b0, pl_ready_o}, 32'd0);
      check("rst_mid_idle", {31'b0, start_ready_o}, 32'd1);
      check("rst_mid_count", W'(xfer_t.size() - base), 32'd4);
      cycle();
      cycle();
      rst_ni    = 1'b1;
      src_abort = 1'b0;
      cycle();
      check("rst_mid_no_done", W'(done_t.size() - nd), 32'd0);
      base = xfer_t.size();
      queue_packet(32'h0000_0405, 1, 32'h40, 0);
      start_pkt(32'h0000_0405, 1);
      wait_done(nd);
      check("post_rst_count", W'(xfer_t.size() - base), 32'd3);
      check("post_rst_sb_empty", W'(exp_q.size()), 32'd0);

      // Back-to-back packets with start_i held high
      base = xfer_t.size();
      nd   = done_t.size();
      queue_packet(32'h0000_0506, 1, 32'h50, 0);
      queue_packet(32'h0000_0607, 2, 32'h60, 0);
      header_i = 32'h0000_0506;
      size_i   = 32'd1;
      start_i  = 1'b1;
      rdy      = 1'b0;
      for (int k = 0; k < 50 && !rdy; k++) begin
         @(negedge clk_i);
         rdy = start_ready_o;
         cycle();
      end
      check("b2b_start1", {31'b0, rdy}, 32'd1);
      header_i = 32'h0000_0607;
      size_i   = 32'd2;
      rdy      = 1'b0;
      for (int k = 0; k < 50 && !rdy; k++) begin
         @(negedge clk_i);
         rdy = start_ready_o;
         cycle();
      end
      start_i = 1'b0;
      check("b2b_start2", {31'b0, rdy}, 32'd1);
      wait_done(nd + 1);
      check("b2b_count", W'(xfer_t.size() - base), 32'd7);
      check("b2b_dones", W'(done_t.size() - nd), 32'd2);
      check("b2b_hdr_after_done", {31'b0, (xfer_t[base+3] > done_t[nd])}, 32'd1);
      check("b2b_sb_empty", W'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
